// File: rtl/display_pkg.sv
// Segment patterns and code points shared by the display scan path and its checkers.
// Patterns are active-low over g..a (bit 6..0).
package display_pkg;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_BAD   = 4'hE;
endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the 7-segment encoder: active-low g..a pattern to BCD code.
// Unknown patterns map to CODE_BAD and raise bad.
module seg7_to_bcd
   import display_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] code,
   output logic       bad
);

   always_comb begin
      code = CODE_BAD;
      bad  = 1'b0;
      case (pattern)
         SEG_0:     code = 4'd0;
         SEG_1:     code = 4'd1;
         SEG_2:     code = 4'd2;
         SEG_3:     code = 4'd3;
         SEG_4:     code = 4'd4;
         SEG_5:     code = 4'd5;
         SEG_6:     code = 4'd6;
         SEG_7:     code = 4'd7;
         SEG_8:     code = 4'd8;
         SEG_9:     code = 4'd9;
         SEG_BLANK: code = CODE_BLANK;
         default: begin
            code = CODE_BAD;
            bad  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/display_scan_reader.sv
// Samples a multiplexed active-low 7-segment bus, accepts each digit after a stable dwell,
// and emits a full decoded frame with a one-cycle valid once every digit has been seen.
module display_scan_reader
   import display_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIGITS-1:0]     anodes,
   input  logic [7:0]            segments,
   output logic [4*DIGITS-1:0]   value,
   output logic [DIGITS-1:0]     dp,
   output logic                  err,
   output logic                  valid
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [DIGITS-1:0]   anodes_q, anodes_p;
   logic [7:0]          segments_q, segments_p;
   logic [CW-1:0]       cnt;
   logic [DIGITS-1:0]   mask;
   logic [4*DIGITS-1:0] buf_value;
   logic [DIGITS-1:0]   buf_dp;
   logic [DIGITS-1:0]   buf_bad;

   logic [DIGITS-1:0]   sel;
   logic                cand;
   logic                same;
   logic                commit;
   logic                frame_done;
   logic [3:0]          code;
   logic                bad;
   logic [4*DIGITS-1:0] nxt_value;
   logic [DIGITS-1:0]   nxt_dp;
   logic [DIGITS-1:0]   nxt_bad;

   seg7_to_bcd u_dec (
      .pattern (segments_q[6:0]),
      .code    (code),
      .bad     (bad)
   );

   // A candidate has exactly one anode low; sel is then one-hot on that digit.
   assign sel        = ~anodes_q;
   assign cand       = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
   assign same       = {anodes_q, segments_q} == {anodes_p, segments_p};
   assign commit     = same && cand && (cnt == CNT_LAST);
   assign frame_done = commit && (&(mask | sel));

   always_comb begin
      nxt_value = buf_value;
      nxt_dp    = buf_dp;
      nxt_bad   = buf_bad;
      for (int k = 0; k < DIGITS; k++) begin
         if (sel[k]) begin
            nxt_value[4*k +: 4] = code;
            nxt_dp[k]           = ~segments_q[7];
            nxt_bad[k]          = bad;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         anodes_q   <= '0;
         segments_q <= '0;
         anodes_p   <= '1;
         segments_p <= '1;
         cnt        <= '0;
         mask       <= '0;
         buf_value  <= '0;
         buf_dp     <= '0;
         buf_bad    <= '0;
         value      <= '0;
         dp         <= '0;
         err        <= 1'b0;
         valid      <= 1'b0;
      end else begin
         anodes_p   <= anodes_q;
         segments_p <= segments_q;
         anodes_q   <= anodes;
         segments_q <= segments;
         valid      <= 1'b0;

         if (!cand)
            cnt <= '0;
         else if (!same)
            cnt <= CW'(1);
         else if (cnt < CNT_MAX)
            cnt <= cnt + CW'(1);

         if (commit) begin
            buf_value <= nxt_value;
            buf_dp    <= nxt_dp;
            if (frame_done) begin
               value   <= nxt_value;
               dp      <= nxt_dp;
               err     <= |nxt_bad;
               valid   <= 1'b1;
               mask    <= '0;
               buf_bad <= '0;
            end else begin
               mask    <= mask | sel;
               buf_bad <= nxt_bad;
            end
         end
      end
   end

endmodule

// File: tb/tb_display_scan_reader.sv
// Directed bench: expected frames are queued as each scan is driven and checked on valid.
module tb_display_scan_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  anodes;
   logic [7:0]  segments;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        err;
   logic        valid;

   typedef struct {
      logic [15:0] v;
      logic [3:0]  d;
      logic        e;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   display_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .anodes   (anodes),
      .segments (segments),
      .value    (value),
      .dp       (dp),
      .err      (err),
      .valid    (valid)
   );

   function automatic logic [7:0] seg(input int d);
      logic [7:0] s;
      case (d)
         0: s = 8'hC0;
         1: s = 8'hF9;
         2: s = 8'hA4;
         3: s = 8'hB0;
         4: s = 8'h99;
         5: s = 8'h92;
         6: s = 8'h82;
         7: s = 8'hF8;
         8: s = 8'h80;
         9: s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   task automatic show(input int k, input logic [7:0] s, input int n);
      anodes   = ~(4'(1) << k);
      segments = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [15:0] v, input logic [3:0] d, input logic e);
      exp_t x;
      x.v = v;
      x.d = d;
      x.e = e;
      sbq.push_back(x);
   endtask

   always @(negedge clk) begin
      if (valid) begin
         exp_t x;
         n_cmp++;
         assert (sbq.size() > 0) else begin
            n_bad++;
            $error("FAIL unexpected_valid observed=1 expected=0");
         end
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            n_cmp++;
            assert (value === x.v) else begin
               n_bad++;
               $error("FAIL frame_value observed=%h expected=%h", value, x.v);
            end
            n_cmp++;
            assert (dp === x.d) else begin
               n_bad++;
               $error("FAIL frame_dp observed=%b expected=%b", dp, x.d);
            end
            n_cmp++;
            assert (err === x.e) else begin
               n_bad++;
               $error("FAIL frame_err observed=%b expected=%b", err, x.e);
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      anodes   = 4'hF;
      segments = 8'hFF;
      repeat (3) @(negedge clk);
      n_cmp++;
      assert (value === 16'h0) else begin n_bad++; $error("FAIL rst_value observed=%h expected=0000", value); end
      n_cmp++;
      assert (dp === 4'h0) else begin n_bad++; $error("FAIL rst_dp observed=%b expected=0000", dp); end
      n_cmp++;
      assert (err === 1'b0) else begin n_bad++; $error("FAIL rst_err observed=%b expected=0", err); end
      n_cmp++;
      assert (valid === 1'b0) else begin n_bad++; $error("FAIL rst_valid observed=%b expected=0", valid); end
      rst = 1'b0;
      @(negedge clk);

      // basic scan 1,2,3,4
      push(16'h4321, 4'b0000, 1'b0);
      show(0, seg(1), 6);
      show(1, seg(2), 6);
      show(2, seg(3), 6);
      show(3, seg(4), 6);

      // blank digit, 8 with DP lit
      push(16'h7F58, 4'b0001, 1'b0);
      show(0, 8'h00, 6);
      show(1, seg(5), 6);
      show(2, 8'hFF, 6);
      show(3, seg(7), 6);

      // bad pattern on digit 1, DP on digit 3
      push(16'h69E0, 4'b1000, 1'b1);
      show(0, seg(0), 6);
      show(1, 8'hD5, 6);
      show(2, seg(9), 6);
      show(3, 8'h02, 6);

      // following clean frame clears err
      push(16'h6202, 4'b0000, 1'b0);
      show(0, seg(2), 6);
      show(1, seg(0), 6);
      show(2, seg(2), 6);
      show(3, seg(6), 6);

      // glitches: all anodes low, then a short wrong pattern on digit 2
      push(16'h9317, 4'b0000, 1'b0);
      show(0, seg(7), 6);
      anodes   = 4'b0000;
      segments = seg(5);
      repeat (3) @(negedge clk);
      show(1, seg(1), 6);
      show(2, seg(8), 2);
      show(2, seg(3), 6);
      show(3, seg(9), 6);

      // reset after three digits; post-reset scan starts at digit 3
      show(0, seg(9), 6);
      show(1, seg(9), 6);
      show(2, seg(9), 6);
      rst      = 1'b1;
      anodes   = 4'hF;
      segments = 8'hFF;
      repeat (2) @(negedge clk);
      n_cmp++;
      assert (value === 16'h0) else begin n_bad++; $error("FAIL midrst_value observed=%h expected=0000", value); end
      n_cmp++;
      assert (valid === 1'b0) else begin n_bad++; $error("FAIL midrst_valid observed=%b expected=0", valid); end
      rst = 1'b0;
      @(negedge clk);
      push(16'h8765, 4'b0000, 1'b0);
      show(3, seg(8), 6);
      show(0, seg(5), 6);
      show(1, seg(6), 6);
      show(2, seg(7), 6);

      // long dwell on the first digit and on the completing digit
      push(16'h1234, 4'b0000, 1'b0);
      show(0, seg(4), 40);
      show(1, seg(3), 6);
      show(2, seg(2), 6);
      show(3, seg(1), 40);

      // a repeated commit of digit 3 above would complete this frame early
      show(0, seg(5), 6);
      show(1, seg(5), 6);
      show(2, seg(5), 6);
      push(16'h0555, 4'b0000, 1'b0);
      show(3, seg(0), 6);

      anodes   = 4'hF;
      segments = 8'hFF;
      repeat (8) @(negedge clk);
      n_cmp++;
      assert (sbq.size() == 0) else begin
         n_bad++;
         $error("FAIL frames_missing observed=%0d expected=0", sbq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_scan_reader.md
# display_scan_reader

Receive-side counterpart of the 7-segment display path. The block samples a time-multiplexed, active-low 4-digit display bus (digit-select anodes plus 8 segment lines including DP). It waits for each digit's pattern to hold stable, decodes it back to BCD, and emits one complete frame with a single-cycle `valid` pulse once every digit position has been captured. It sits on the board-test/loopback side, checking what the display driver actually puts on the pins.

## Interface
Parameters:
- `DIGITS`, 4: number of multiplexed digit positions.
- `STABLE_CYCLES`, 4: consecutive identical registered samples required to accept a digit. Legal range is ≥ 2.

Ports:
- `clk` input, 1 bit: the only clock. Everything is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `anodes` input, `DIGITS` bits: digit select, active-low. Bit k low selects digit k.
- `segments` input, 8 bits: active-low segment lines. Bit 7 is DP, bits 6..0 are g..a.
- `value` output, 4·`DIGITS` bits: frame code for each digit. Nibble k belongs to digit k.
- `dp` output, `DIGITS` bits: decimal point lit, per digit, active-high.
- `err` output, 1 bit: set when the emitted frame contains an unrecognised pattern.
- `valid` output, 1 bit: one-cycle pulse marking that a new frame is on `value`, `dp` and `err`.

## Operation
- Input stage: `anodes` and `segments` are registered once into a sample register with no decode.
- A sample is a candidate when exactly one `anodes` bit is low; index k is that bit's position.
  - A non-candidate sample (all high, or two or more low) clears the stability counter.
  - A non-candidate sample is never committed.
- Stability counter:
  - Compare the current sample {anodes, segments} with the previous sample.
  - If they differ, the counter becomes 1 (candidate) or 0 (non-candidate).
  - If they match and the counter is below `STABLE_CYCLES`, increment.
  - Commit happens when the samples match, the sample is a candidate, and the counter equals `STABLE_CYCLES`−1. After commit the counter saturates at `STABLE_CYCLES`, so there is exactly one commit per dwell.
- Decode of `segments[6:0]` to a code:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F (blank) → 0xF.
  - Any other pattern → 0xE and sets that digit's bad flag.
  - DP is set as `dp`=~`segments[7]`.
- Commit writes digit k's code, DP and bad flag into the frame buffer and sets bit k of a captured mask.
  - Re-committing an already captured k overwrites its data; the mask is unchanged.
- Frame completion: when a commit makes the mask all-ones, on that same edge:
  - `value` and `dp` load the assembled frame, including the new digit.
  - `err` loads the OR of all bad flags.
  - `valid` is set to 1.
  - The mask and bad flags clear.
- `valid` is high for exactly one cycle. `value`, `dp` and `err` hold until the next frame.
- Reset values:
  - `value`=0, `dp`=0, `err`=0, `valid`=0.
  - Counter, mask, frame buffer and sample registers are all 0.
  - Previous-sample registers are all-ones, which reads as an idle bus.
- Reset mid-frame discards the partially captured frame. The first frame after reset needs all `DIGITS` digits again.

## Timing
- Inputs change before edge E and then hold. They are registered at E; the counter reaches 1 at E+1.
- The commit for digit k happens at edge E+`STABLE_CYCLES`.
- If that commit completes the frame, `value`/`dp`/`err` update and `valid`=1 after edge E+`STABLE_CYCLES`. `valid` returns to 0 after the next edge.
- A glitch shorter than `STABLE_CYCLES` samples never commits. It restarts the count for the pattern that follows.
- A dwell longer than `STABLE_CYCLES` produces no additional commits.
- Frames can be emitted back-to-back, limited only by commit rate. Minimum frame period is `DIGITS`·`STABLE_CYCLES` cycles.

## Structure
- Shared package `display_pkg` holds:
  - the segment pattern constants SEG_0…SEG_9 and SEG_BLANK (active-low, 7-bit);
  - the codes CODE_BLANK=4'hF and CODE_BAD=4'hE.
- One combinational sub-module, `seg7_to_bcd`: takes a 7-bit pattern and returns a 4-bit code plus a bad flag. It is reusable by other checkers.
- The top level contains the sample register, stability counter, commit logic, frame buffer and output registers.

## Test plan
- Scan digits 0..3 with `segments` for 1,2,3,4, each held 6 cycles, defaults → one `valid` pulse, `value`=16'h4321, `dp`=0, `err`=0.
- Digit 2 showing 0x7F and digit 0 showing 0x00 with DP low → frame nibble2=0xF, nibble0=0x8, `dp`[0]=1, `err`=0.
- Digit 1 showing 0x55 → nibble1=0xE, `err`=1 on that frame; next clean frame returns `err`=0.
- 3-cycle glitch of `anodes`=4'b0000 and of a 2-cycle wrong pattern mid-scan → neither is committed, frame value unaffected.
- Assert `rst` after digits 0..2 are captured, then scan one full frame → exactly one `valid`, carrying post-reset data only.
- Single digit held 40 cycles → one commit only, no `valid` until the other three digits are seen.
